// File: rtl/linear_weight_update_pkg.sv
// fpu_defines: tensor-header constants and FSM state encoding shared by linear_weight_update.
package fpu_defines;
  localparam logic [31:0] TENSOR_NDIMS_2D = 32'd2;
  localparam int HDR_NDIMS = 0;
  localparam int HDR_DIM0  = 1;
  localparam int HDR_DIM1  = 2;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_D0,
    ST_D1,
    ST_WH0,
    ST_WH1,
    ST_WH2,
    ST_CHK,
    ST_LD,
    ST_WB,
    ST_DONE,
    ST_ERR
  } wu_state_e;
endpackage

// File: rtl/linear_weight_update_sgd_elem_update.sv
// sgd_elem_update: w - (g >>> LR_SHIFT); saturates on signed overflow when LINEAR_WUPDATE_SATURATE_EN is defined.
module sgd_elem_update
  import fpu_defines::*;
#(
  parameter int LR_SHIFT = 4
) (
  input  logic [31:0] wv_i,
  input  logic [31:0] gv_i,
  output logic [31:0] result_o
);
  logic [31:0] step;
  logic [31:0] diff;
  assign step = $signed(gv_i) >>> LR_SHIFT;
  assign diff = wv_i - step;
`ifdef LINEAR_WUPDATE_SATURATE_EN
  logic ovf;
  // overflow only when operands differ in sign and the result left w's sign
  assign ovf      = (wv_i[31] != step[31]) && (diff[31] != wv_i[31]);
  assign result_o = ovf ? (wv_i[31] ? 32'h8000_0000 : 32'h7fff_ffff) : diff;
`else
  assign result_o = diff;
`endif
endmodule

// File: rtl/linear_weight_update.sv
// linear_weight_update: SGD update u = w - (g >>> LR_SHIFT) over 2-D tensors in memory.
// Build option: LINEAR_WUPDATE_SATURATE_EN selects saturating subtraction.
module linear_weight_update
  import fpu_defines::*;
#(
  parameter int LR_SHIFT  = 4,
  parameter int MAX_ELEMS = 65536
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        go,
  output logic        done,
  output logic        err,
  output logic        w_r_en_o,
  output logic        w_w_en_o,
  output logic        w_avail_o,
  output logic [31:0] w_ptr_o,
  output logic [31:0] w_data_store_o,
  output logic        w_write_through_o,
  input  logic        w_done_i,
  input  logic [31:0] w_data_load_i,
  input  logic [31:0] w_region_begin_i,
  output logic        g_r_en_o,
  output logic        g_w_en_o,
  output logic        g_avail_o,
  output logic [31:0] g_ptr_o,
  output logic [31:0] g_data_store_o,
  output logic        g_write_through_o,
  input  logic        g_done_i,
  input  logic [31:0] g_data_load_i,
  input  logic [31:0] g_region_begin_i,
  output logic        u_r_en_o,
  output logic        u_w_en_o,
  output logic        u_avail_o,
  output logic [31:0] u_ptr_o,
  output logic [31:0] u_data_store_o,
  output logic        u_write_through_o,
  input  logic        u_done_i,
  input  logic [31:0] u_region_begin_i,
  input  logic [31:0] u_region_end_i
);
  wu_state_e   state_q, state_d;
  logic        w_req_q, w_req_d, g_req_q, g_req_d, u_req_q, u_req_d;
  logic        w_got_q, w_got_d, g_got_q, g_got_d, u_got_q, u_got_d;
  logic [31:0] w_ptr_q, w_ptr_d, g_ptr_q, g_ptr_d, u_ptr_q, u_ptr_d;
  logic [31:0] u_data_q, u_data_d;
  logic        u_wt_q, u_wt_d;
  logic [31:0] wv_q, wv_d, gv_q, gv_d;
  logic [31:0] dim0_q, dim0_d, dim1_q, dim1_d;
  logic [31:0] elem_q, elem_d;
  logic [31:0] total;
  logic [31:0] upd;
  logic        rd_ok, u_full, last_slot, too_big;
  sgd_elem_update #(.LR_SHIFT(LR_SHIFT)) u_elem (
    .wv_i     (wv_q),
    .gv_i     (gv_q),
    .result_o (upd)
  );
  assign total     = dim0_q * dim1_q;
  assign rd_ok     = w_got_q && g_got_q;
  assign u_full    = u_ptr_q >= u_region_end_i;
  assign last_slot = u_ptr_q == u_region_end_i - 32'd1;
  assign too_big   = ({32'd0, wv_q} * {32'd0, dim0_q}) > 64'(MAX_ELEMS);
  assign done              = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign err               = state_q == ST_ERR;
  assign w_r_en_o          = w_req_q;
  assign w_w_en_o          = 1'b0;
  assign w_avail_o         = w_req_q;
  assign w_ptr_o           = w_ptr_q;
  assign w_data_store_o    = 32'd0;
  assign w_write_through_o = 1'b0;
  assign g_r_en_o          = g_req_q;
  assign g_w_en_o          = 1'b0;
  assign g_avail_o         = g_req_q;
  assign g_ptr_o           = g_ptr_q;
  assign g_data_store_o    = 32'd0;
  assign g_write_through_o = 1'b0;
  assign u_r_en_o          = 1'b0;
  assign u_w_en_o          = u_req_q;
  assign u_avail_o         = u_req_q;
  assign u_ptr_o           = u_ptr_q;
  assign u_data_store_o    = u_data_q;
  assign u_write_through_o = u_wt_q;
  always_comb begin
    state_d = state_q;
    w_req_d = w_req_q;
    g_req_d = g_req_q;
    u_req_d = u_req_q;
    w_got_d = w_got_q;
    g_got_d = g_got_q;
    u_got_d = u_got_q;
    w_ptr_d = w_ptr_q;
    g_ptr_d = g_ptr_q;
    u_ptr_d = u_ptr_q;
    u_data_d = u_data_q;
    u_wt_d = u_wt_q;
    wv_d = wv_q;
    gv_d = gv_q;
    dim0_d = dim0_q;
    dim1_d = dim1_q;
    elem_d = elem_q;
    // each handle completes independently; the FSM below acts once the got flags say so
    if (w_req_q && w_done_i) begin
      w_req_d = 1'b0;
      w_got_d = 1'b1;
      w_ptr_d = w_ptr_q + 32'd1;
      wv_d = w_data_load_i;
    end
    if (g_req_q && g_done_i) begin
      g_req_d = 1'b0;
      g_got_d = 1'b1;
      g_ptr_d = g_ptr_q + 32'd1;
      gv_d = g_data_load_i;
    end
    if (u_req_q && u_done_i) begin
      u_req_d = 1'b0;
      u_got_d = 1'b1;
      u_ptr_d = u_ptr_q + 32'd1;
      u_wt_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: if (go) begin
        state_d = ST_HDR;
        w_ptr_d = w_region_begin_i;
        g_ptr_d = g_region_begin_i;
        u_ptr_d = u_region_begin_i;
        w_req_d = 1'b1;
        g_req_d = 1'b1;
        elem_d = 32'd0;
      end
      ST_HDR: if (rd_ok) begin
        w_got_d = 1'b0;
        g_got_d = 1'b0;
        state_d = (wv_q != TENSOR_NDIMS_2D || gv_q != TENSOR_NDIMS_2D) ? ST_ERR : ST_D0;
        w_req_d = state_d == ST_D0;
        g_req_d = state_d == ST_D0;
      end
      ST_D0: if (rd_ok) begin
        w_got_d = 1'b0;
        g_got_d = 1'b0;
        state_d = (wv_q != gv_q) ? ST_ERR : ST_D1;
        w_req_d = state_d == ST_D1;
        g_req_d = state_d == ST_D1;
        dim0_d = wv_q;
      end
      ST_D1: if (rd_ok) begin
        w_got_d = 1'b0;
        g_got_d = 1'b0;
        state_d = (wv_q != gv_q || too_big || u_full) ? ST_ERR : ST_WH0;
        dim1_d = wv_q;
        u_req_d = state_d == ST_WH0;
        u_data_d = TENSOR_NDIMS_2D;
        u_wt_d = (state_d == ST_WH0) && last_slot;
      end
      ST_WH0: if (u_got_q) begin
        u_got_d = 1'b0;
        state_d = u_full ? ST_ERR : ST_WH1;
        u_req_d = !u_full;
        u_data_d = dim0_q;
        u_wt_d = !u_full && last_slot;
      end
      ST_WH1: if (u_got_q) begin
        u_got_d = 1'b0;
        state_d = u_full ? ST_ERR : ST_WH2;
        u_req_d = !u_full;
        u_data_d = dim1_q;
        u_wt_d = !u_full && (last_slot || total == 32'd0);
      end
      ST_WH2: if (u_got_q) begin
        u_got_d = 1'b0;
        state_d = ST_CHK;
      end
      ST_CHK: begin
        state_d = (elem_q == total) ? ST_DONE : (u_full ? ST_ERR : ST_LD);
        w_req_d = state_d == ST_LD;
        g_req_d = state_d == ST_LD;
      end
      ST_LD: if (rd_ok) begin
        w_got_d = 1'b0;
        g_got_d = 1'b0;
        state_d = ST_WB;
        u_req_d = 1'b1;
        u_data_d = upd;
        u_wt_d = last_slot || (elem_q == total - 32'd1);
      end
      ST_WB: if (u_got_q) begin
        u_got_d = 1'b0;
        elem_d = elem_q + 32'd1;
        state_d = ST_CHK;
      end
      ST_DONE, ST_ERR: if (!go) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_l) begin
      state_q <= ST_IDLE;
      w_req_q <= 1'b0;
      g_req_q <= 1'b0;
      u_req_q <= 1'b0;
      w_got_q <= 1'b0;
      g_got_q <= 1'b0;
      u_got_q <= 1'b0;
      w_ptr_q <= 32'd0;
      g_ptr_q <= 32'd0;
      u_ptr_q <= 32'd0;
      u_data_q <= 32'd0;
      u_wt_q <= 1'b0;
      wv_q <= 32'd0;
      gv_q <= 32'd0;
      dim0_q <= 32'd0;
      dim1_q <= 32'd0;
      elem_q <= 32'd0;
    end else begin
      state_q <= state_d;
      w_req_q <= w_req_d;
      g_req_q <= g_req_d;
      u_req_q <= u_req_d;
      w_got_q <= w_got_d;
      g_got_q <= g_got_d;
      u_got_q <= u_got_d;
      w_ptr_q <= w_ptr_d;
      g_ptr_q <= g_ptr_d;
      u_ptr_q <= u_ptr_d;
      u_data_q <= u_data_d;
      u_wt_q <= u_wt_d;
      wv_q <= wv_d;
      gv_q <= gv_d;
      dim0_q <= dim0_d;
      dim1_q <= dim1_d;
      elem_q <= elem_d;
    end
  end
endmodule

// File: tb/tb_linear_weight_update.sv
// tb_linear_weight_update: randomized-latency memory responders plus an arithmetic reference model.
module tb_linear_weight_update;
  import fpu_defines::*;
  localparam int LR  = 4;
  localparam int WB0 = 4;
  localparam int GB0 = 0;
  localparam int UB0 = 8;
  logic clk, rst_l, go, done, err;
  logic w_r_en_o, w_w_en_o, w_avail_o, w_write_through_o, w_done_i;
  logic [31:0] w_ptr_o, w_data_store_o, w_data_load_i, w_region_begin_i;
  logic g_r_en_o, g_w_en_o, g_avail_o, g_write_through_o, g_done_i;
  logic [31:0] g_ptr_o, g_data_store_o, g_data_load_i, g_region_begin_i;
  logic u_r_en_o, u_w_en_o, u_avail_o, u_write_through_o, u_done_i;
  logic [31:0] u_ptr_o, u_data_store_o, u_region_begin_i, u_region_end_i;
  logic [31:0] wmem [128];
  logic [31:0] gmem [128];
  logic [31:0] umem [128];
  int checks, fails, w_reads, g_reads, u_writes, wt_cnt;
  logic [31:0] wt_addr, u_max_addr;
  linear_weight_update #(.LR_SHIFT(LR), .MAX_ELEMS(65536)) dut (
    .clk(clk), .rst_l(rst_l), .go(go), .done(done), .err(err),
    .w_r_en_o(w_r_en_o), .w_w_en_o(w_w_en_o), .w_avail_o(w_avail_o), .w_ptr_o(w_ptr_o),
    .w_data_store_o(w_data_store_o), .w_write_through_o(w_write_through_o),
    .w_done_i(w_done_i), .w_data_load_i(w_data_load_i), .w_region_begin_i(w_region_begin_i),
    .g_r_en_o(g_r_en_o), .g_w_en_o(g_w_en_o), .g_avail_o(g_avail_o), .g_ptr_o(g_ptr_o),
    .g_data_store_o(g_data_store_o), .g_write_through_o(g_write_through_o),
    .g_done_i(g_done_i), .g_data_load_i(g_data_load_i), .g_region_begin_i(g_region_begin_i),
    .u_r_en_o(u_r_en_o), .u_w_en_o(u_w_en_o), .u_avail_o(u_avail_o), .u_ptr_o(u_ptr_o),
    .u_data_store_o(u_data_store_o), .u_write_through_o(u_write_through_o),
    .u_done_i(u_done_i), .u_region_begin_i(u_region_begin_i), .u_region_end_i(u_region_end_i)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    int cnt;
    bit pend;
    w_done_i = 0; w_data_load_i = 0; pend = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      w_done_i = 0;
      if (!w_r_en_o) pend = 0;
      else if (!pend) begin pend = 1; cnt = $urandom_range(1, 5); end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin w_done_i = 1; w_data_load_i = wmem[w_ptr_o[6:0]]; w_reads++; pend = 0; end
      end
    end
  end
  initial begin
    int cnt;
    bit pend;
    g_done_i = 0; g_data_load_i = 0; pend = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      g_done_i = 0;
      if (!g_r_en_o) pend = 0;
      else if (!pend) begin pend = 1; cnt = $urandom_range(1, 5); end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin g_done_i = 1; g_data_load_i = gmem[g_ptr_o[6:0]]; g_reads++; pend = 0; end
      end
    end
  end
  initial begin
    int cnt;
    bit pend;
    u_done_i = 0; pend = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      u_done_i = 0;
      if (!u_w_en_o) pend = 0;
      else if (!pend) begin pend = 1; cnt = $urandom_range(1, 5); end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          u_done_i = 1;
          umem[u_ptr_o[6:0]] = u_data_store_o;
          u_writes++;
          if (u_ptr_o > u_max_addr) u_max_addr = u_ptr_o;
          if (u_write_through_o) begin wt_cnt++; wt_addr = u_ptr_o; end
          pend = 0;
        end
      end
    end
  end
  function automatic logic [31:0] ref_upd(input logic [31:0] a, input logic [31:0] b);
    int ai, bi;
    longint r;
    ai = a;
    bi = b;
    bi = bi >>> LR;
    r = longint'(ai) - longint'(bi);
`ifdef LINEAR_WUPDATE_SATURATE_EN
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
    return r[31:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic setup(input int d0, input int d1);
    for (int i = 0; i < 128; i++) begin wmem[i] = $urandom; gmem[i] = $urandom; end
    wmem[WB0 + HDR_NDIMS] = 2; wmem[WB0 + HDR_DIM0] = d0; wmem[WB0 + HDR_DIM1] = d1;
    gmem[GB0 + HDR_NDIMS] = 2; gmem[GB0 + HDR_DIM0] = d0; gmem[GB0 + HDR_DIM1] = d1;
  endtask
  task automatic clear_counts();
    w_reads = 0; g_reads = 0; u_writes = 0; wt_cnt = 0; wt_addr = '1; u_max_addr = 0;
    for (int i = 0; i < 128; i++) umem[i] = 32'hdead_beef;
  endtask
  task automatic run();
    int n;
    clear_counts();
    @(negedge clk);
    go = 1;
    n = 0;
    while (!done && n < 4000) begin @(negedge clk); n++; end
    chk("done_reached", 32'(done), 32'd1);
  endtask
  task automatic finish_op();
    go = 0;
    @(negedge clk);
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("err_clear", 32'(err), 32'd0);
  endtask
  task automatic check_result(input int d0, input int d1);
    int n;
    n = d0 * d1;
    chk("err_low", 32'(err), 32'd0);
    chk("hdr_ndims", umem[UB0], 32'd2);
    chk("hdr_dim0", umem[UB0 + 1], d0);
    chk("hdr_dim1", umem[UB0 + 2], d1);
    for (int i = 0; i < n; i++)
      chk($sformatf("data%0d", i), umem[UB0 + 3 + i], ref_upd(wmem[WB0 + 3 + i], gmem[GB0 + 3 + i]));
    chk("u_writes", u_writes, 3 + n);
    chk("w_reads", w_reads, 3 + n);
    chk("g_reads", g_reads, 3 + n);
    chk("w_ptr", w_ptr_o, WB0 + 3 + n);
    chk("g_ptr", g_ptr_o, GB0 + 3 + n);
    chk("u_ptr", u_ptr_o, UB0 + 3 + n);
    chk("wt_cnt", wt_cnt, 1);
    chk("wt_addr", wt_addr, UB0 + 2 + n);
  endtask
  initial begin
    int n, d0, d1;
    checks = 0; fails = 0;
    rst_l = 1; go = 0;
    w_region_begin_i = WB0; g_region_begin_i = GB0;
    u_region_begin_i = UB0; u_region_end_i = 100;
    clear_counts();
    repeat (2) @(negedge clk);
    rst_l = 0;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_avail", {29'd0, w_avail_o, g_avail_o, u_avail_o}, 32'd0);
    chk("rst_uptr", u_ptr_o, 32'd0);
    setup(2, 2);
    wmem[WB0 + 3] = 10; wmem[WB0 + 4] = 20; wmem[WB0 + 5] = 30; wmem[WB0 + 6] = 40;
    gmem[GB0 + 3] = 16; gmem[GB0 + 4] = 32; gmem[GB0 + 5] = -16; gmem[GB0 + 6] = 160;
    run();
    check_result(2, 2);
    chk("dir_e0", umem[UB0 + 3], 32'd9);
    chk("dir_e1", umem[UB0 + 4], 32'd18);
    chk("dir_e2", umem[UB0 + 5], 32'd31);
    chk("dir_e3", umem[UB0 + 6], 32'd30);
    finish_op();
    setup(2, 2);
    gmem[GB0 + HDR_DIM1] = 3;
    run();
    chk("mm_err", 32'(err), 32'd1);
    chk("mm_writes", u_writes, 32'd0);
    finish_op();
    setup(0, 5);
    run();
    check_result(0, 5);
    finish_op();
    setup(1, 1);
    wmem[WB0 + 3] = 32'h8000_0000; gmem[GB0 + 3] = 32'h10;
    run();
    check_result(1, 1);
`ifdef LINEAR_WUPDATE_SATURATE_EN
    chk("ovf_sat", umem[UB0 + 3], 32'h8000_0000);
`else
    chk("ovf_wrap", umem[UB0 + 3], 32'h7fff_ffff);
`endif
    finish_op();
    for (int t = 0; t < 6; t++) begin
      d0 = $urandom_range(1, 4);
      d1 = $urandom_range(1, 4);
      setup(d0, d1);
      run();
      check_result(d0, d1);
      finish_op();
    end
    setup(2, 2);
    u_region_end_i = UB0 + 5;
    run();
    chk("ovr_err", 32'(err), 32'd1);
    chk("ovr_writes", u_writes, 32'd5);
    chk("ovr_max", u_max_addr, UB0 + 4);
    finish_op();
    u_region_end_i = 100;
    setup(3, 3);
    clear_counts();
    go = 1;
    n = 0;
    while (!(u_writes == 5 && w_r_en_o) && n < 4000) begin @(negedge clk); n++; end
    chk("ld3_reached", 32'(u_writes == 5 && w_r_en_o), 32'd1);
    rst_l = 1;
    @(negedge clk);
    rst_l = 0;
    go = 0;
    chk("mid_rst_req", {29'd0, w_r_en_o, g_r_en_o, u_w_en_o}, 32'd0);
    chk("mid_rst_avail", {29'd0, w_avail_o, g_avail_o, u_avail_o}, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_wptr", w_ptr_o, 32'd0);
    @(negedge clk);
    chk("mid_rst_idle", {30'd0, done, w_r_en_o}, 32'd0);
    run();
    check_result(3, 3);
    finish_op();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/linear_weight_update.md
Name: linear_weight_update

Overview:
- SGD weight-update stage downstream of the linear weight-gradient stage.
- Consumes the weight tensor and the gradient tensor that stage writes, both in memory through mem_handle ports.
- Writes the updated weight tensor w' = w - (g >>> LR_SHIFT), element by element, with an identical tensor header.
- Started by the layer sequencer via go/done.

Parameters:
- LR_SHIFT, 4: learning rate as a power of two, lr = 2^-LR_SHIFT; arithmetic right shift of the gradient.
- MAX_ELEMS, 65536: largest legal dim0*dim1; larger shapes go to ERR.

Ports:
- clk  input  1  clock.
- rst_l  input  1  reset; one clock; reset is synchronous and active-high (rst_l=1 resets).
- w  mem_handle  -  weight tensor source (read only).
- g  mem_handle  -  gradient tensor source (read only).
- u  mem_handle  -  updated weight tensor destination (write only).
- go  input  1  start; level, sampled in IDLE.
- done  output  1  high in DONE and ERR.
- err  output  1  high in ERR only (header mismatch, ndims!=2, or size > MAX_ELEMS).

Behaviour:
- Tensor layout: word0 ndims (must be 2), word1 dim0, word2 dim1, then dim0*dim1 32-bit signed data words, row-major.
- Reset (rst_l=1 at posedge): state=IDLE; done=0, err=0.
  - All handle outputs 0: w_en, r_en, avail, ptr, data_store, write_through.
  - Internal registers 0: elem count, loaded dims, wv, gv.
  - Applies mid-operation too: any in-flight request is dropped and avail falls the next cycle.
- Memory handshake, per access: hold r_en|w_en and avail high, with ptr/data_store stable, until the handle's done pulse. In the done cycle drop r_en/w_en/avail and increment ptr. One outstanding access per handle.
- States and transitions:
  - IDLE -> HDR (go=1). On entry to HDR, w.ptr, g.ptr, u.ptr <= region_begin.
  - HDR: read word0 from w and g in parallel; each value latches on its own done. Advance when both are latched. Either value !=2 -> ERR.
  - D0, D1: same pattern for dim0 and dim1. Any w/g mismatch -> ERR. dim0*dim1 > MAX_ELEMS -> ERR. dim0*dim1 == 0 is legal.
  - WH0, WH1, WH2: write 2, dim0, dim1 to u, one word each.
  - CHK -> DONE if elem==dim0*dim1, else LD.
  - LD: read w and g in parallel; latch wv and gv; wait for both.
  - WB: write wv - (gv >>> LR_SHIFT) to u. write_through=1 on the last element, and also whenever u.ptr==u.region_end-1. On done, elem++ and go to CHK.
  - DONE: stays until go=0, then IDLE.
  - ERR: stays until go=0, then IDLE; err clears on leaving.
- Arithmetic: 32-bit two's complement; shift is arithmetic (sign-preserving); subtraction wraps modulo 2^32 unless SATURATE_EN.
- Zero-size tensor: header still written (3 words), no data reads, DONE.
- u region overrun (u.ptr reaching region_end before the last element): ERR; no write issued past region_end-1.
- go dropped mid-operation: ignored; go is only sampled in IDLE/DONE/ERR.
- Latency per element: max(w, g read latency) + u write latency + 2 cycles (LD/WB exit plus CHK).

Optional Feature:
- LINEAR_WUPDATE_SATURATE_EN defined: the subtraction saturates to 0x7FFFFFFF / 0x80000000 on signed overflow.
- Undefined: the subtraction wraps. No other behaviour changes.

Decomposition:
- Shared package (fpu_defines): TENSOR_NDIMS_2D=2, header word offsets (HDR_NDIMS=0, HDR_DIM0=1, HDR_DIM1=2), state enum typedef.
- Sub-module sgd_elem_update: combinational/1-register datapath (shift, subtract, optional saturate) with inputs wv, gv and output result; the FSM instantiates it.

Test Plan:
- w=[2,2,2 | 10,20,30,40], g=[2,2,2 | 16,32,-16,160], LR_SHIFT=4 -> u=[2,2,2 | 9,18,31,30]; done=1, err=0; write_through only on the final word.
- g header dims [2,2,3] vs w [2,2,2] -> ERR after D1, err=1, zero writes to u; go=0 -> IDLE, err=0.
- w=g=[2,0,5] -> u=[2,0,5], no data reads, done=1.
- w=0x80000000, g=0x10 (LR_SHIFT=4): without macro u=0x7FFFFFFF (wrap); with LINEAR_WUPDATE_SATURATE_EN u=0x80000000.
- Random 1-5 cycle done latencies on w, g, u, independently skewed -> results match the reference model; ptr advances exactly once per done.
- rst_l=1 for one cycle during LD of element 3 -> next cycle all avail/r_en/w_en=0, state IDLE; re-run with go completes correctly.
